// File: rtl/fair_queue_front.sv
// Per-source circular FIFOs feeding one output register, with the pop chosen by an external fair scheduler.
// Define FAIR_QUEUE_ERR_CHK_EN to build in the sticky protocol checker behind err.
module fair_queue_front #(
    parameter int LG_N     = 2,
    parameter int LG_DEPTH = 2,
    parameter int W        = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [(1<<LG_N)-1:0]       in_valid,
    input  logic [(1<<LG_N)*W-1:0]     in_data,
    output logic [(1<<LG_N)-1:0]       in_ready,
    output logic [(1<<LG_N)-1:0]       sched_req,
    input  logic [LG_N:0]              sched_y,
    output logic                       out_valid,
    output logic [W-1:0]               out_data,
    output logic [LG_N-1:0]            out_src,
    input  logic                       out_ready,
    output logic                       err
);

    localparam int N     = 1 << LG_N;
    localparam int DEPTH = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] PTR_ONE = {{LG_DEPTH{1'b0}}, 1'b1};

    logic [LG_DEPTH:0] head_q [N];
    logic [LG_DEPTH:0] head_d [N];
    logic [LG_DEPTH:0] tail_q [N];
    logic [LG_DEPTH:0] tail_d [N];
    logic [W-1:0]      mem_q  [N][DEPTH];

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [LG_N-1:0]   out_src_q, out_src_d;

    logic [N-1:0]      empty, full, push;
    logic              slot_free, pop;
    logic [LG_N-1:0]   sel;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            empty[i] = (head_q[i] == tail_q[i]);
            full[i]  = (head_q[i][LG_DEPTH-1:0] == tail_q[i][LG_DEPTH-1:0]) &&
                       (head_q[i][LG_DEPTH] != tail_q[i][LG_DEPTH]);
        end
    end

    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign slot_free = !out_valid_q || out_ready;
    assign sched_req = ~empty & {N{slot_free}};
    assign sel       = sched_y[LG_N-1:0];
    assign pop       = !sched_y[LG_N] && slot_free && !empty[sel];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        for (int i = 0; i < N; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = push[i] ? tail_q[i] + PTR_ONE : tail_q[i];
        end
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[sel][head_q[sel][LG_DEPTH-1:0]];
            out_src_d   = sel;
            head_d[sel] = head_q[sel] + PTR_ONE;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    // Storage is left unreset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem_q[i][tail_q[i][LG_DEPTH-1:0]] <= in_data[i*W +: W];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef FAIR_QUEUE_ERR_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (!sched_y[LG_N] && !sched_req[sel]) || (|(in_valid & full));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fair_queue_front.sv
// Bench for fair_queue_front: directed scenarios plus a randomized run against a queue-based model
// with a round-robin scheduler attached; err expectations follow FAIR_QUEUE_ERR_CHK_EN.
module tb_fair_queue_front;

    localparam int N     = 4;
    localparam int W     = 64;
    localparam int DEPTH = 4;
`ifdef FAIR_QUEUE_ERR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     sched_req;
    logic [2:0]       sched_y;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;
    logic             out_ready;
    logic             err;

    fair_queue_front #(.LG_N(2), .LG_DEPTH(2), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sched_req(sched_req), .sched_y(sched_y),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    // Round-robin scheduler, overridable with a forced grant.
    logic       force_en;
    logic [2:0] force_y;
    logic [1:0] rr_ptr;
    logic [1:0] rr_idx;

    always_comb begin
        sched_y = 3'b100;
        rr_idx  = 2'd0;
        if (force_en) begin
            sched_y = force_y;
        end else begin
            for (int k = N-1; k >= 0; k--) begin
                rr_idx = rr_ptr + 2'(k);
                if (sched_req[rr_idx]) sched_y = {1'b0, rr_idx};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr <= 2'd0;
        else if (!force_en && !sched_y[2]) rr_ptr <= sched_y[1:0] + 2'd1;
    end

    // Reference model
    logic [W-1:0] mq [N][$];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   m_src;
    logic         m_err;
    int           n_total = 0;
    int           n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_update();
        logic         sf, pop_m, bad;
        logic [N-1:0] req, fullb;
        int           s;
        sf = !m_valid || out_ready;
        for (int i = 0; i < N; i++) begin
            req[i]   = (mq[i].size() != 0) && sf;
            fullb[i] = (mq[i].size() == DEPTH);
        end
        s     = int'(sched_y[1:0]);
        pop_m = !sched_y[2] && sf && (mq[s].size() != 0);
        bad   = (!sched_y[2] && !req[s]) || (|(in_valid & fullb));
        if (CHK && bad) m_err = 1'b1;
        if (pop_m) begin
            m_data  = mq[s].pop_front();
            m_src   = sched_y[1:0];
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (in_valid[i] && !fullb[i]) mq[i].push_back(in_data[i*W +: W]);
    endtask

    task automatic check_all();
        logic [N-1:0] er, eq;
        for (int i = 0; i < N; i++) begin
            er[i] = (mq[i].size() < DEPTH);
            eq[i] = (mq[i].size() != 0) && (!m_valid || out_ready);
        end
        chk("in_ready", in_ready, er);
        chk("sched_req", sched_req, eq);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
        chk("err", err, m_err);
    endtask

    // Called at a negedge: drive, advance the model, cross one posedge, check at the next negedge.
    task automatic step(input logic [N-1:0] iv, input logic [N*W-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_async_rst();
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_req", sched_req, 4'b0000);
        chk("arst_err", err, 1'b0);
        chk("arst_rdy", in_ready, 4'b1111);
        check_all();
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [N*W-1:0] put(input int s, input logic [W-1:0] d);
        logic [N*W-1:0] v;
        v = '0;
        v[s*W +: W] = d;
        return v;
    endfunction

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   iv;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        force_en  = 1'b1;
        force_y   = 3'b100;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_data", out_data, 64'h0);
        rst = 1'b0;

        // Single push on source 2 through to the output register
        force_en = 1'b0;
        step(4'b0100, put(2, 64'hA5), 1'b1);
        chk("r32_req", sched_req, 4'b0100);
        step(4'b0000, '0, 1'b1);
        chk("r32_ov", out_valid, 1'b1);
        chk("r32_data", out_data, 64'hA5);
        chk("r32_src", out_src, 2'd2);
        chk("r32_req0", sched_req, 4'b0000);

        // Fill source 0, then attempt overflow
        step(4'b0000, '0, 1'b1);
        force_en = 1'b1;
        force_y  = 3'b100;
        for (int k = 0; k < 4; k++) step(4'b0001, put(0, 64'h100 + 64'(k)), 1'b0);
        chk("r33_rdy", in_ready[0], 1'b0);
        step(4'b0001, put(0, 64'hDEAD), 1'b0);
        chk("r33_err", err, CHK);
        force_en = 1'b0;
        repeat (6) step(4'b0000, '0, 1'b1);

        // Round-robin across four sources, two entries each
        do_async_rst();
        force_en = 1'b1;
        for (int e = 0; e < 2; e++) begin
            d = '0;
            for (int s = 0; s < N; s++) d[s*W +: W] = 64'h200 + 64'(s*16 + e);
            step(4'b1111, d, 1'b0);
        end
        force_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(4'b0000, '0, 1'b1);
            chk("r34_src", out_src, 64'(k % 4));
            chk("r34_data", out_data, 64'h200 + 64'((k % 4) * 16 + k / 4));
        end

        // Back-pressure: output holds while out_ready is low
        force_en = 1'b1;
        step(4'b0000, '0, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b1000, put(3, 64'h300 + 64'(k)), 1'b0);
        force_en = 1'b0;
        step(4'b0000, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, '0, 1'b0);
            chk("r35_req", sched_req, 4'b0000);
            chk("r35_ov", out_valid, 1'b1);
            chk("r35_data", out_data, 64'h300);
        end
        for (int k = 1; k < 3; k++) begin
            step(4'b0000, '0, 1'b1);
            chk("r35_next", out_data, 64'h300 + 64'(k));
        end
        step(4'b0000, '0, 1'b1);

        // Asynchronous reset mid-stream
        force_en = 1'b1;
        d = '0;
        for (int s = 0; s < N; s++) d[s*W +: W] = 64'h400 + 64'(s);
        step(4'b1111, d, 1'b0);
        force_en = 1'b0;
        step(4'b0000, '0, 1'b1);
        chk("r36_pre_ov", out_valid, 1'b1);
        out_ready = 1'b0;
        do_async_rst();

        // Grant to a source that is not requesting
        force_en = 1'b1;
        force_y  = 3'b100;
        step(4'b0010, put(1, 64'h555), 1'b0);
        chk("r37_req", sched_req, 4'b0010);
        force_y = 3'b000;
        step(4'b0000, '0, 1'b0);
        chk("r37_ov", out_valid, 1'b0);
        chk("r37_err", err, CHK);
        do_async_rst();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            force_en = ($urandom_range(0, 7) == 0);
            force_y  = 3'($urandom_range(0, 7));
            iv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            for (int s = 0; s < N; s++) d[s*W +: W] = {$urandom, $urandom};
            step(iv, d, ($urandom_range(0, 3) != 0));
            if (c % 200 == 199) do_async_rst();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fair_queue_front.md
FAIR_QUEUE_FRONT -- requirements
Module: fair_queue_front

Interface
REQ-001 Parameter LG_N, default 2, log2 of the number of source queues; N = 2^LG_N.
REQ-002 Parameter LG_DEPTH, default 2, log2 of the entries per source queue; DEPTH = 2^LG_DEPTH.
REQ-003 Parameter W, default 64, payload width.
REQ-004 clk  input  1  sole clock; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  N  per-source push request.
REQ-007 in_data  input  N*W  per-source payload; source i occupies bits [i*W +: W].
REQ-008 in_ready  output  N  per-source accept; 1 when that queue is not full.
REQ-009 sched_req  output  N  request vector driven to the fair scheduler.
REQ-010 sched_y  input  LG_N+1  scheduler grant; MSB=1 means no grant, else low LG_N bits are the source index.
REQ-011 out_valid  output  1  output register holds an entry.
REQ-012 out_data  output  W  payload of the output entry.
REQ-013 out_src  output  LG_N  source index of the output entry.
REQ-014 out_ready  input  1  downstream accepts the output entry.
REQ-015 err  output  1  sticky protocol-error flag; see Configuration.

Function
REQ-016 Each source owns a circular FIFO: head and tail pointers LG_DEPTH+1 bits wide, wrapping modulo 2*DEPTH; empty when the pointers are equal, full when the low bits are equal and the MSBs differ.
REQ-017 Push on source i occurs when in_valid[i] & in_ready[i]; in_ready[i] = !full[i], computed from registered state only. A full queue does not accept a push in the cycle it is popped.
REQ-018 slot_free = !out_valid | out_ready.
REQ-019 sched_req[i] = !empty[i] & slot_free; sched_req is all-zero whenever the output slot cannot take an entry, so the scheduler's rotation advances only on real grants.
REQ-020 Pop occurs when sched_y[LG_N]==0 & slot_free & !empty[sched_y[LG_N-1:0]]; the head entry of the selected queue loads out_data, its index loads out_src, out_valid is set, and the head pointer increments.
REQ-021 At most one pop per cycle across all queues; any number of pushes per cycle, one per source.
REQ-022 If out_valid & out_ready and no pop occurs, out_valid clears next cycle; out_data and out_src hold their values.
REQ-023 A pop and an out_ready handshake in the same cycle replace the output entry back-to-back with no bubble.
REQ-024 Latency: a push at edge t sets sched_req at t+1; if granted, out_valid is 1 after edge t+2.
REQ-025 A push and a pop on the same queue in the same cycle are legal when the queue is neither full nor empty; occupancy is unchanged.
REQ-026 Per-source ordering is FIFO; no ordering is guaranteed across sources.

Reset
REQ-027 While rst is high, all head and tail pointers, out_valid, out_src and err are 0, and out_data is 0; consequently in_ready = all-ones and sched_req = 0.
REQ-028 An assertion of rst at any point, including mid-transfer, discards all queued entries and the output entry immediately, without waiting for a clock edge.
REQ-029 FIFO storage arrays are not reset; they are never read while empty.

Configuration
REQ-030 Macro FAIR_QUEUE_ERR_CHK_EN, when defined, compiles in the checker: err sets and stays set until reset if sched_y grants a source whose sched_req bit is 0, or if in_valid[i] & !in_ready[i] (an attempted overflow; the push is dropped).
REQ-031 Without FAIR_QUEUE_ERR_CHK_EN, err is tied to 0 and no checker logic exists; the datapath is identical in both builds.

Verification
REQ-032 Reset, then a push of 0xA5 on source 2 at cycle 1, with the scheduler returning 2 and out_ready=1: sched_req=4'b0100 at cycle 2, out_valid=1 with out_data=0xA5 and out_src=2 at cycle 3, and sched_req=0 at cycle 3.
REQ-033 Four pushes to source 0 with DEPTH=4 and out_ready=0: in_ready[0]=0 after the 4th push; a 5th push attempt sets err=1 only in a FAIR_QUEUE_ERR_CHK_EN build, and the queue contents are unchanged.
REQ-034 All four sources loaded with 2 entries each, a round-robin scheduler attached, out_ready=1: 8 outputs with out_src sequence 0,1,2,3,0,1,2,3 and per-source data in push order.
REQ-035 out_ready held at 0 with entries queued: sched_req=0 and no pop; out_valid and out_data are stable until out_ready rises, then one transfer per cycle.
REQ-036 rst asserted asynchronously mid-stream with 3 entries queued and out_valid=1: out_valid, sched_req and err are 0 before the next edge, and in_ready=all-ones.
REQ-037 Forced sched_y=0 while sched_req=4'b0010 in a FAIR_QUEUE_ERR_CHK_EN build: no pop, and err=1 next cycle.
